ddr_frame_writer: RTL and testbench
===================================

Name: ddr_frame_writer

Overview:
- Buffers the 64-bit pixel-word stream from the camera capture path and writes it to DDR as fixed-length bursts through a MIG-style app interface.
- Generates frame-buffer addresses and ping-pongs between two frame buffers.
- Reports the last completed buffer to the read/display side.
- Runs entirely in the DDR user clock domain; upstream delivers wr_en/wr_data already synchronised.

Parameters:
- DATA_W, 64, write data width (bits).
- ADDR_W, 28, DDR byte-address width.
- BURST_LEN, 8, words per DDR write burst; power of 2, ≥2.
- FIFO_DEPTH, 512, input FIFO depth in words; power of 2, ≥2*BURST_LEN.
- FRAME_WORDS, 76800, words per frame (640x480x16bpp/64); must be a multiple of BURST_LEN.
- BASE0, 28'h0000000, byte base address of buffer 0.
- BASE1, 28'h0100000, byte base address of buffer 1.

Ports:
- clk_ddr  in  1  DDR user clock; all logic on rising edge.
- sys_rst  in  1  synchronous active-high reset.
- cfg_done  in  1  sensor configuration complete; enables frame acceptance.
- frame_start  in  1  single-cycle pulse at start of each frame (from vsync).
- wr_en  in  1  pixel word valid.
- wr_data  in  DATA_W  pixel word.
- app_rdy  in  1  DDR controller accepts command.
- app_en  out  1  command valid.
- app_cmd  out  3  command; always 3'b000 (write).
- app_addr  out  ADDR_W  burst start byte address.
- app_wdf_rdy  in  1  DDR controller accepts write data.
- app_wdf_wren  out  1  write data valid.
- app_wdf_data  out  DATA_W  write data.
- app_wdf_end  out  1  last word of burst.
- frame_done  out  1  one-cycle pulse when a full frame is committed.
- rd_buf_sel  out  1  index of last completed buffer.
- overflow  out  1  sticky; set when a word is dropped.
- frame_err  out  1  one-cycle pulse when a frame is aborted short.

Behaviour:
- Reset: state IDLE; FIFO emptied; all outputs 0; wr_buf = 0; addr = BASE0; word_cnt = 0.
- FIFO:
  - wr_en with FIFO full drops the word and sets overflow.
  - wr_en is ignored in IDLE.
  - Simultaneous push and pop on a full FIFO is legal; the word is not dropped.
- overflow clears only on the cycle frame_start is accepted.
- States:
  - IDLE: wait for cfg_done=1 and frame_start. Then addr = wr_buf ? BASE1 : BASE0, word_cnt = 0, FIFO cleared, go to COLLECT. frame_start while cfg_done=0 is ignored.
  - COLLECT: go to WDATA when fifo_count ≥ BURST_LEN.
  - WDATA:
    - Pop one word per cycle while app_wdf_rdy=1; app_wdf_wren = app_wdf_rdy gated.
    - Data is first-word-fall-through, so there is no bubble between words.
    - app_wdf_end is asserted with the BURST_LEN-th word.
    - After the last word is accepted, go to CMD.
  - CMD:
    - Hold app_en=1 with stable app_addr until a cycle where app_rdy=1.
    - On that cycle: addr += BURST_LEN*DATA_W/8 and word_cnt += BURST_LEN.
    - Then, if word_cnt == FRAME_WORDS: pulse frame_done, set rd_buf_sel = wr_buf, toggle wr_buf, go to IDLE.
    - Otherwise go to COLLECT.
- frame_start arriving mid-frame (COLLECT/WDATA/CMD):
  - Latch it as pending.
  - The current burst always completes (WDATA/CMD are never interrupted).
  - On return to the COLLECT decision point, pending is consumed: pulse frame_err, clear the FIFO, leave rd_buf_sel and wr_buf unchanged, reload addr to the current buffer base, word_cnt = 0, stay in COLLECT.
  - If the same CMD completes the frame, normal completion takes priority and pending is treated as the next frame's start, so IDLE is skipped.
- Address arithmetic is modulo 2^ADDR_W and wraps silently.
- Latency: the first app_wdf_wren occurs 1 cycle after the BURST_LEN-th word is written (FIFO write-to-count 1 cycle).
- sys_rst asserted mid-burst:
  - Abandons the burst immediately; outputs go to reset values the next cycle.
  - The DDR controller must be reset alongside this block.

Test Plan:
- Nominal two frames, FRAME_WORDS=32, BURST_LEN=8, ready always 1, continuous wr_en: 4 bursts at BASE0 addr 0x00,0x40,0x80,0xC0, frame_done, rd_buf_sel=0; second frame at BASE1, rd_buf_sel=1.
- Backpressure, app_wdf_rdy toggling 1/0 and app_rdy low 5 cycles: no word lost or duplicated; app_wdf_end exactly on 8th word; app_addr stable while app_en high.
- Overflow, app_wdf_rdy=0 and 520 words pushed with FIFO_DEPTH=512: overflow=1 after word 513; holds until next accepted frame_start.
- Short frame, frame_start after 12 words: current burst finishes; frame_err pulses; next burst at BASE0+0x00; rd_buf_sel unchanged.
- Gating: frame_start with cfg_done=0 produces no app_en/app_wdf_wren; the first frame_start after cfg_done=1 starts capture.
- Reset mid-WDATA: all outputs 0 the next cycle; after release, a frame restarts cleanly at BASE0.

Source files
------------

// File: rtl/ddr_frame_writer.sv
// Camera-to-DDR frame writer: buffers pixel words in a FWFT FIFO and writes
// fixed-length bursts through a MIG-style app interface, ping-ponging between two frame buffers.
module ddr_frame_writer #(
    parameter int                DATA_W      = 64,
    parameter int                ADDR_W      = 28,
    parameter int                BURST_LEN   = 8,
    parameter int                FIFO_DEPTH  = 512,
    parameter int                FRAME_WORDS = 76800,
    parameter logic [ADDR_W-1:0] BASE0       = 28'h0000000,
    parameter logic [ADDR_W-1:0] BASE1       = 28'h0100000
) (
    input  logic              clk_ddr,
    input  logic              sys_rst,
    input  logic              cfg_done,
    input  logic              frame_start,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              app_rdy,
    output logic              app_en,
    output logic [2:0]        app_cmd,
    output logic [ADDR_W-1:0] app_addr,
    input  logic              app_wdf_rdy,
    output logic              app_wdf_wren,
    output logic [DATA_W-1:0] app_wdf_data,
    output logic              app_wdf_end,
    output logic              frame_done,
    output logic              rd_buf_sel,
    output logic              overflow,
    output logic              frame_err
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int BEAT_W = $clog2(BURST_LEN);
    localparam int WC_W   = $clog2(FRAME_WORDS + 1);

    localparam logic [CNT_W-1:0]  DEPTH_C       = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0]  BURST_CNT_C   = CNT_W'(BURST_LEN);
    localparam logic [BEAT_W-1:0] LAST_BEAT_C   = BEAT_W'(BURST_LEN - 1);
    localparam logic [WC_W-1:0]   BURST_WC_C    = WC_W'(BURST_LEN);
    localparam logic [WC_W-1:0]   FRAME_WC_C    = WC_W'(FRAME_WORDS);
    localparam logic [ADDR_W-1:0] BURST_BYTES_C = ADDR_W'(BURST_LEN * DATA_W / 8);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_WDATA   = 2'd2,
        S_CMD     = 2'd3
    } state_t;

    state_t             state_r;
    state_t             state_s;
    logic [DATA_W-1:0]  mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [PTR_W-1:0]   wr_idx_s;
    logic [CNT_W-1:0]   count_r;
    logic [BEAT_W-1:0]  beat_r;
    logic [ADDR_W-1:0]  addr_r;
    logic [ADDR_W-1:0]  base_s;
    logic [WC_W-1:0]    word_cnt_r;
    logic [WC_W-1:0]    word_cnt_inc_s;
    logic               wr_buf_r;
    logic               rd_buf_sel_r;
    logic               pending_r;
    logic               overflow_r;
    logic               frame_done_r;
    logic               frame_err_r;
    logic               active_s;
    logic               full_s;
    logic               pop_s;
    logic               push_s;
    logic               drop_s;
    logic               cmd_fire_s;
    logic               frame_end_s;
    logic               start_s;
    logic               abort_s;
    logic               fifo_clear_s;
    logic               base_sel_s;

    assign active_s       = (state_r != S_IDLE);
    assign full_s         = (count_r == DEPTH_C);
    assign pop_s          = (state_r == S_WDATA) && app_wdf_rdy;
    assign cmd_fire_s     = (state_r == S_CMD) && app_rdy;
    assign word_cnt_inc_s = word_cnt_r + BURST_WC_C;
    assign frame_end_s    = cmd_fire_s && (word_cnt_inc_s == FRAME_WC_C);

    // A frame_start latched mid-frame becomes the next frame's start when the
    // same command completes the current frame, so IDLE is skipped.
    assign start_s      = ((state_r == S_IDLE) && cfg_done && frame_start) ||
                          (frame_end_s && (pending_r || frame_start));
    assign abort_s      = (state_r == S_COLLECT) && pending_r;
    assign fifo_clear_s = start_s || abort_s;

    // A clearing cycle still keeps the word arriving on it as the new first word.
    assign push_s   = wr_en && active_s && (!full_s || pop_s || fifo_clear_s);
    assign drop_s   = wr_en && active_s && !push_s;
    assign wr_idx_s = fifo_clear_s ? {PTR_W{1'b0}} : wr_ptr_r;

    assign base_sel_s = frame_end_s ? ~wr_buf_r : wr_buf_r;
    assign base_s     = base_sel_s ? BASE1 : BASE0;

    assign app_en       = (state_r == S_CMD);
    assign app_cmd      = 3'b000;
    assign app_addr     = addr_r;
    assign app_wdf_wren = pop_s;
    assign app_wdf_data = pop_s ? mem_r[rd_ptr_r] : {DATA_W{1'b0}};
    assign app_wdf_end  = pop_s && (beat_r == LAST_BEAT_C);
    assign frame_done   = frame_done_r;
    assign rd_buf_sel   = rd_buf_sel_r;
    assign overflow     = overflow_r;
    assign frame_err    = frame_err_r;

    // Next-state decode for the burst sequencer.
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (start_s) state_s = S_COLLECT;
                else         state_s = S_IDLE;
            end
            S_COLLECT: begin
                if (pending_r)                   state_s = S_COLLECT;
                else if (count_r >= BURST_CNT_C) state_s = S_WDATA;
                else                             state_s = S_COLLECT;
            end
            S_WDATA: begin
                if (pop_s && (beat_r == LAST_BEAT_C)) state_s = S_CMD;
                else                                  state_s = S_WDATA;
            end
            S_CMD: begin
                if (!cmd_fire_s)      state_s = S_CMD;
                else if (!frame_end_s) state_s = S_COLLECT;
                else if (start_s)      state_s = S_COLLECT;
                else                   state_s = S_IDLE;
            end
            default: state_s = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_ddr) begin
        if (sys_rst) state_r <= S_IDLE;
        else         state_r <= state_s;
    end

    // FIFO storage; emptiness is tracked by the pointers, so no reset needed.
    always_ff @(posedge clk_ddr) begin
        if (push_s) mem_r[wr_idx_s] <= wr_data;
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk_ddr) begin
        if (sys_rst) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else if (fifo_clear_s) begin
            rd_ptr_r <= {PTR_W{1'b0}};
            wr_ptr_r <= push_s ? PTR_W'(1) : {PTR_W{1'b0}};
            count_r  <= push_s ? CNT_W'(1) : {CNT_W{1'b0}};
        end else begin
            if (push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Frame bookkeeping: addresses, buffer ping-pong, status flags.
    always_ff @(posedge clk_ddr) begin
        if (sys_rst) begin
            beat_r       <= {BEAT_W{1'b0}};
            addr_r       <= BASE0;
            word_cnt_r   <= {WC_W{1'b0}};
            wr_buf_r     <= 1'b0;
            rd_buf_sel_r <= 1'b0;
            pending_r    <= 1'b0;
            overflow_r   <= 1'b0;
            frame_done_r <= 1'b0;
            frame_err_r  <= 1'b0;
        end else begin
            frame_done_r <= frame_end_s;
            frame_err_r  <= abort_s;
            overflow_r   <= fifo_clear_s ? 1'b0 : (overflow_r | drop_s);
            if (pop_s) beat_r <= beat_r + BEAT_W'(1);
            if (frame_end_s) begin
                rd_buf_sel_r <= wr_buf_r;
                wr_buf_r     <= ~wr_buf_r;
            end
            if (fifo_clear_s) begin
                addr_r     <= base_s;
                word_cnt_r <= {WC_W{1'b0}};
            end else if (cmd_fire_s) begin
                addr_r     <= addr_r + BURST_BYTES_C;
                word_cnt_r <= word_cnt_inc_s;
            end
            if (start_s)      pending_r <= 1'b0;
            else if (abort_s) pending_r <= frame_start;
            else              pending_r <= pending_r | (frame_start && active_s);
        end
    end

endmodule

// File: tb/tb_ddr_frame_writer.sv
// Directed bench for ddr_frame_writer: small frames, backpressure, overflow,
// short-frame abort, cfg gating and mid-burst reset against hand-computed expectations.
module tb_ddr_frame_writer;

    localparam int          DW = 64;
    localparam int          AW = 28;
    localparam int          BL = 8;
    localparam int          FD = 512;
    localparam int          FW = 32;
    localparam logic [AW-1:0] B0 = 28'h0000000;
    localparam logic [AW-1:0] B1 = 28'h0100000;

    logic          clk_ddr = 1'b0;
    logic          sys_rst;
    logic          cfg_done;
    logic          frame_start;
    logic          wr_en;
    logic [DW-1:0] wr_data;
    logic          app_rdy;
    logic          app_en;
    logic [2:0]    app_cmd;
    logic [AW-1:0] app_addr;
    logic          app_wdf_rdy;
    logic          app_wdf_wren;
    logic [DW-1:0] app_wdf_data;
    logic          app_wdf_end;
    logic          frame_done;
    logic          rd_buf_sel;
    logic          overflow;
    logic          frame_err;

    int            n_checks = 0;
    int            n_pass   = 0;
    logic [DW-1:0] q_data[$];
    logic [AW-1:0] q_addr[$];
    int            done_cnt = 0;
    int            err_cnt  = 0;
    int            beat_idx = 0;
    int            mode     = 0;
    int            stall    = 0;
    logic          prev_en  = 1'b0;
    logic          prev_rdy = 1'b0;
    logic [AW-1:0] prev_addr = '0;

    ddr_frame_writer #(
        .DATA_W(DW), .ADDR_W(AW), .BURST_LEN(BL), .FIFO_DEPTH(FD),
        .FRAME_WORDS(FW), .BASE0(B0), .BASE1(B1)
    ) dut (
        .clk_ddr(clk_ddr), .sys_rst(sys_rst), .cfg_done(cfg_done),
        .frame_start(frame_start), .wr_en(wr_en), .wr_data(wr_data),
        .app_rdy(app_rdy), .app_en(app_en), .app_cmd(app_cmd), .app_addr(app_addr),
        .app_wdf_rdy(app_wdf_rdy), .app_wdf_wren(app_wdf_wren),
        .app_wdf_data(app_wdf_data), .app_wdf_end(app_wdf_end),
        .frame_done(frame_done), .rd_buf_sel(rd_buf_sel),
        .overflow(overflow), .frame_err(frame_err)
    );

    initial forever #5 clk_ddr = ~clk_ddr;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // DDR controller model: 0 = always ready, 1 = backpressure, 2 = write data stalled.
    initial begin
        app_rdy     = 1'b1;
        app_wdf_rdy = 1'b1;
        forever begin
            @(posedge clk_ddr); #1;
            case (mode)
                1: begin
                    app_wdf_rdy = ~app_wdf_rdy;
                    if (app_en) stall++;
                    else        stall = 0;
                    app_rdy = (stall > 5);
                end
                2: begin
                    app_wdf_rdy = 1'b0;
                    app_rdy     = 1'b1;
                end
                default: begin
                    app_wdf_rdy = 1'b1;
                    app_rdy     = 1'b1;
                end
            endcase
        end
    end

    // Interface monitor: collects accepted beats and commands, checks framing on the fly.
    initial forever begin
        @(negedge clk_ddr);
        if (sys_rst) begin
            beat_idx = 0;
            prev_en  = 1'b0;
        end else begin
            if (app_wdf_wren) begin
                q_data.push_back(app_wdf_data);
                check_eq("wdf_end", 64'(app_wdf_end), 64'(beat_idx == BL - 1));
                beat_idx = (beat_idx + 1) % BL;
            end
            if (app_en) begin
                check_eq("app_cmd", 64'(app_cmd), 64'd0);
                if (prev_en && !prev_rdy) check_eq("addr_stable", 64'(app_addr), 64'(prev_addr));
                if (app_rdy) q_addr.push_back(app_addr);
            end
            if (frame_done) done_cnt++;
            if (frame_err)  err_cnt++;
            prev_en   = app_en;
            prev_rdy  = app_rdy;
            prev_addr = app_addr;
        end
    end

    task automatic tick();
        @(posedge clk_ddr); #1;
    endtask

    task automatic pulse_start();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic push_words(input logic [63:0] first, input int n);
        for (int i = 0; i < n; i++) begin
            wr_en   = 1'b1;
            wr_data = first + 64'(i);
            tick();
        end
        wr_en = 1'b0;
    endtask

    task automatic wait_ev(input bit on_err, input int target, input string tag);
        int k = 0;
        while (((on_err ? err_cnt : done_cnt) < target) && (k < 800)) begin
            tick();
            k++;
        end
        check_eq(tag, 64'((on_err ? err_cnt : done_cnt) >= target), 64'd1);
    endtask

    task automatic check_bursts(input logic [AW-1:0] base, input logic [63:0] first,
                                input int nb, input string tag);
        check_eq({tag, "_ncmd"}, 64'(q_addr.size()), 64'(nb));
        check_eq({tag, "_nwords"}, 64'(q_data.size()), 64'(nb * BL));
        for (int i = 0; i < nb && i < q_addr.size(); i++)
            check_eq({tag, "_addr"}, 64'(q_addr[i]), 64'(base + AW'(i * 64)));
        for (int i = 0; i < nb * BL && i < q_data.size(); i++)
            check_eq({tag, "_data"}, q_data[i], first + 64'(i));
        q_addr.delete();
        q_data.delete();
    endtask

    task automatic check_rst_outputs(input string tag);
        check_eq({tag, "_app_en"},   64'(app_en),       64'd0);
        check_eq({tag, "_app_cmd"},  64'(app_cmd),      64'd0);
        check_eq({tag, "_app_addr"}, 64'(app_addr),     64'd0);
        check_eq({tag, "_wren"},     64'(app_wdf_wren), 64'd0);
        check_eq({tag, "_wdata"},    app_wdf_data,      64'd0);
        check_eq({tag, "_wend"},     64'(app_wdf_end),  64'd0);
        check_eq({tag, "_done"},     64'(frame_done),   64'd0);
        check_eq({tag, "_rd_buf"},   64'(rd_buf_sel),   64'd0);
        check_eq({tag, "_ovf"},      64'(overflow),     64'd0);
        check_eq({tag, "_ferr"},     64'(frame_err),    64'd0);
    endtask

    initial begin
        sys_rst     = 1'b1;
        cfg_done    = 1'b0;
        frame_start = 1'b0;
        wr_en       = 1'b0;
        wr_data     = '0;
        repeat (3) tick();
        sys_rst = 1'b0;
        tick();
        check_rst_outputs("reset");

        // frame_start and data before cfg_done must not start anything
        pulse_start();
        push_words(64'h1000, 16);
        repeat (10) tick();
        check_eq("gate_words", 64'(q_data.size()), 64'd0);
        check_eq("gate_cmds",  64'(q_addr.size()), 64'd0);

        // two nominal frames, buffers 0 then 1
        cfg_done = 1'b1;
        pulse_start();
        push_words(64'h0, FW);
        wait_ev(1'b0, 1, "f1_done");
        check_bursts(B0, 64'h0, 4, "f1");
        check_eq("f1_rd_buf", 64'(rd_buf_sel), 64'd0);

        pulse_start();
        push_words(64'h100, FW);
        wait_ev(1'b0, 2, "f2_done");
        check_bursts(B1, 64'h100, 4, "f2");
        check_eq("f2_rd_buf", 64'(rd_buf_sel), 64'd1);

        // short frame: restart after 12 words, first burst still completes
        pulse_start();
        push_words(64'h200, 12);
        pulse_start();
        wait_ev(1'b1, 1, "short_err");
        check_bursts(B0, 64'h200, 1, "short");
        check_eq("short_rd_buf", 64'(rd_buf_sel), 64'd1);
        check_eq("short_no_done", 64'(done_cnt), 64'd2);
        push_words(64'h300, FW);
        wait_ev(1'b0, 3, "f3_done");
        check_bursts(B0, 64'h300, 4, "f3");
        check_eq("f3_rd_buf", 64'(rd_buf_sel), 64'd0);

        // backpressure on both data and command channels
        mode = 1;
        pulse_start();
        push_words(64'h400, FW);
        wait_ev(1'b0, 4, "bp_done");
        check_bursts(B1, 64'h400, 4, "bp");
        check_eq("bp_rd_buf", 64'(rd_buf_sel), 64'd1);

        // overflow with write data stalled
        mode = 2;
        tick();
        pulse_start();
        push_words(64'h1_0000, FD);
        check_eq("ovf_full_no_drop", 64'(overflow), 64'd0);
        push_words(64'h1_0000 + 64'(FD), 1);
        check_eq("ovf_set", 64'(overflow), 64'd1);
        push_words(64'h1_0000 + 64'(FD + 1), 7);
        repeat (10) tick();
        check_eq("ovf_sticky", 64'(overflow), 64'd1);
        pulse_start();
        check_eq("ovf_held_pending", 64'(overflow), 64'd1);
        mode = 0;
        wait_ev(1'b1, 2, "ovf_err");
        check_eq("ovf_cleared", 64'(overflow), 64'd0);
        check_eq("ovf_rd_buf", 64'(rd_buf_sel), 64'd1);
        check_bursts(B0, 64'h1_0000, 1, "ovf");

        // reset in the middle of a burst
        push_words(64'h600, BL);
        begin
            int k = 0;
            while (!app_wdf_wren && k < 20) begin
                @(negedge clk_ddr);
                k++;
            end
        end
        check_eq("midrst_in_burst", 64'(app_wdf_wren), 64'd1);
        sys_rst = 1'b1;
        @(negedge clk_ddr);
        check_rst_outputs("midrst");
        @(posedge clk_ddr); #1;
        sys_rst = 1'b0;
        q_data.delete();
        q_addr.delete();
        tick();
        pulse_start();
        push_words(64'h700, FW);
        wait_ev(1'b0, 5, "post_rst_done");
        check_bursts(B0, 64'h700, 4, "post_rst");
        check_eq("post_rst_rd_buf", 64'(rd_buf_sel), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
